decode_issue: RTL and testbench

Decode, register-read and writeback stage sitting directly upstream of the ALU. It accepts 32-bit instruction words over a valid/ready handshake and decodes them into the ALU control fields. It reads operands from an internal 16×32 register file, forwarding in-flight results where needed, and holds them in an issue register that drives the ALU. When each instruction completes, it writes the ALU result back to the register file and updates the NZCV flags register.

---
 rtl/decode_issue.sv | 150 +++++++++++++++
 tb/tb_decode_issue.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_issue.sv
// Decode / register-read / writeback stage feeding the ALU: decodes instruction words, reads a 16x32 regfile, holds an issue register.
// Latency: issue outputs update one clock after capture; writeback and flags land on the retire edge (forwarded into a same-edge capture).
// Backpressure: instr_ready = !issue_valid || exe_ready; a stalled issue register holds every output and suppresses writeback.
//
// Ports:
//   clk, reset (async, active-low)
//   instr_valid / instr / instr_ready   : upstream instruction handshake
//   exe_ready / issue_valid             : ALU consume / issue register occupied
//   in1, in2, sbit, cond, opcode, srcontrol, imvalue : registered issue fields
//   inflags                             : NZCV flags register
//   alu_result, alu_outflags            : ALU outputs for the issued instruction
//   dbg_addr / dbg_data                 : asynchronous regfile read port
module decode_issue (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_valid,
    input  logic [31:0] instr,
    output logic        instr_ready,
    input  logic        exe_ready,
    output logic        issue_valid,
    output logic [31:0] in1,
    output logic [31:0] in2,
    output logic        sbit,
    output logic [3:0]  cond,
    output logic [3:0]  opcode,
    output logic [2:0]  srcontrol,
    output logic [15:0] imvalue,
    output logic [3:0]  inflags,
    input  logic [31:0] alu_result,
    input  logic [3:0]  alu_outflags,
    input  logic [3:0]  dbg_addr,
    output logic [31:0] dbg_data
);

    logic [31:0] r_regs [16];
    logic [3:0]  r_flags;
    logic        r_issue_valid;
    logic [31:0] r_in1;
    logic [31:0] r_in2;
    logic        r_sbit;
    logic [3:0]  r_cond;
    logic [3:0]  r_opcode;
    logic [2:0]  r_srcontrol;
    logic [15:0] r_imvalue;
    logic [3:0]  r_rd;

    logic        w_ready;
    logic        w_capture;
    logic        w_retire;
    logic        w_cond_met;
    logic        w_wb_en;
    logic        w_flg_en;
    logic [3:0]  w_rn;
    logic [3:0]  w_rm;
    logic [31:0] w_op1;
    logic [31:0] w_op2;
    logic        w_n;
    logic        w_z;
    logic        w_c;
    logic        w_v;

    assign w_ready   = !r_issue_valid || exe_ready;
    assign w_capture = instr_valid && w_ready;
    assign w_retire  = r_issue_valid && exe_ready;

    assign {w_n, w_z, w_c, w_v} = r_flags;

    // Condition is tested against the committed flags; the previous
    // instruction's update has already landed, so no flag bypass exists.
    always_comb begin
        w_cond_met = 1'b1;
        case (r_cond)
            4'b0001: w_cond_met = w_z;
            4'b0010: w_cond_met = !w_z && (w_n == w_v);
            4'b0011: w_cond_met = !w_z && (w_n != w_v);
            4'b0100: w_cond_met = (w_n == w_v);
            4'b0101: w_cond_met = (w_n != w_v);
            4'b0110: w_cond_met = !w_z && w_c;
            4'b0111: w_cond_met = !w_c;
            4'b1000: w_cond_met = w_c;
            default: w_cond_met = 1'b1;
        endcase
    end

    // Only opcodes 0000-0111 produce a register result.
    assign w_wb_en  = w_retire && w_cond_met && !r_opcode[3];
    assign w_flg_en = w_retire && w_cond_met && (r_sbit || (r_opcode == 4'b1000));

    assign w_rn = instr[15:12];
    assign w_rm = instr[11:8];

    // A capture on the retire edge must see the value being written back.
    assign w_op1 = (w_wb_en && (r_rd == w_rn)) ? alu_result : r_regs[w_rn];
    assign w_op2 = (w_wb_en && (r_rd == w_rm)) ? alu_result : r_regs[w_rm];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 16; i++) begin
                r_regs[i] <= '0;
            end
            r_flags <= '0;
        end else begin
            if (w_wb_en) begin
                r_regs[r_rd] <= alu_result;
            end
            if (w_flg_en) begin
                r_flags <= alu_outflags;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_issue_valid <= 1'b0;
            r_in1         <= '0;
            r_in2         <= '0;
            r_sbit        <= 1'b0;
            r_cond        <= '0;
            r_opcode      <= 4'b1111;
            r_srcontrol   <= '0;
            r_imvalue     <= '0;
            r_rd          <= '0;
        end else if (w_capture) begin
            r_issue_valid <= 1'b1;
            r_in1         <= w_op1;
            r_in2         <= w_op2;
            r_cond        <= instr[31:28];
            r_opcode      <= instr[27:24];
            r_sbit        <= instr[23];
            r_srcontrol   <= instr[22:20];
            r_rd          <= instr[19:16];
            r_imvalue     <= instr[15:0];
        end else if (w_retire) begin
            r_issue_valid <= 1'b0;
        end
    end

    assign instr_ready = w_ready;
    assign issue_valid = r_issue_valid;
    assign in1         = r_in1;
    assign in2         = r_in2;
    assign sbit        = r_sbit;
    assign cond        = r_cond;
    assign opcode      = r_opcode;
    assign srcontrol   = r_srcontrol;
    assign imvalue     = r_imvalue;
    assign inflags     = r_flags;
    assign dbg_data    = r_regs[dbg_addr];

endmodule

// File: tb/tb_decode_issue.sv
`timescale 1ns/100ps
module tb_decode_issue;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        instr_valid = 1'b0;
    logic [31:0] instr = '0;
    logic        instr_ready;
    logic        exe_ready = 1'b0;
    logic        issue_valid;
    logic [31:0] in1, in2;
    logic        sbit;
    logic [3:0]  cond, opcode;
    logic [2:0]  srcontrol;
    logic [15:0] imvalue;
    logic [3:0]  inflags;
    logic [31:0] alu_result;
    logic [3:0]  alu_outflags;
    logic [3:0]  dbg_addr = '0;
    logic [31:0] dbg_data;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    decode_issue dut (
        .clk(clk), .reset(reset),
        .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
        .exe_ready(exe_ready), .issue_valid(issue_valid),
        .in1(in1), .in2(in2), .sbit(sbit), .cond(cond), .opcode(opcode),
        .srcontrol(srcontrol), .imvalue(imvalue), .inflags(inflags),
        .alu_result(alu_result), .alu_outflags(alu_outflags),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    // Stand-in ALU: returns {flags, result}; flags = {N, Z, a>=b, a[31]^res[31]}.
    function automatic logic [35:0] alu_fn(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [15:0] imm);
        logic [31:0] r;
        logic [3:0]  f;
        case (op)
            4'd0:    r = a + b;
            4'd1:    r = a - b;
            4'd2:    r = a & b;
            4'd3:    r = a | b;
            4'd4:    r = a ^ b;
            4'd5:    r = b;
            4'd6:    r = {16'h0, imm};
            4'd7:    r = ~b;
            4'd8:    r = a - b;
            default: r = a + {16'h0, imm};
        endcase
        f = {r[31], (r == 32'h0), (a >= b), a[31] ^ r[31]};
        return {f, r};
    endfunction

    always_comb {alu_outflags, alu_result} = alu_fn(opcode, in1, in2, imvalue);

    function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'd1: return z;
            4'd2: return !z && (n == v);
            4'd3: return !z && (n != v);
            4'd4: return n == v;
            4'd5: return n != v;
            4'd6: return !z && cy;
            4'd7: return !cy;
            4'd8: return cy;
            default: return 1'b1;
        endcase
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d] got=%h expected=%h", name, idx, act, exp);
        end
    endtask

    typedef struct {
        logic        vld;
        logic [31:0] ins;
        logic        er;
        logic [3:0]  dba;
        logic        rdy;
        logic        iv;
        logic [31:0] in1;
        logic [31:0] in2;
        logic [3:0]  op;
        logic [3:0]  flg;
        logic [31:0] dbg;
    } vec_t;

    localparam int NV = 19;
    vec_t tbl [NV];

    // Reference model state for the random phase.
    logic [31:0] m_regs [16];
    logic [3:0]  m_flags;
    bit          m_iv;
    logic [31:0] m_ins;
    logic [31:0] m_in1, m_in2;

    initial begin
        // vld, instr, exe_ready, dbg_addr | ready, issue_valid, in1, in2, opcode, flags, dbg_data
        tbl[0]  = '{1, 32'h06010005, 1, 4'd1, 1, 1, 0, 0, 4'h6, 4'b0000, 0};   // MOV r1,#5
        tbl[1]  = '{1, 32'h00021100, 1, 4'd1, 1, 1, 5, 5, 4'h0, 4'b0000, 5};   // ADD r2,r1,r1 (fwd)
        tbl[2]  = '{1, 32'h08001100, 1, 4'd2, 1, 1, 5, 5, 4'h8, 4'b0000, 10};  // CMP r1,r1
        tbl[3]  = '{1, 32'h16030007, 1, 4'd3, 1, 1, 0, 0, 4'h6, 4'b0110, 0};   // MOVEQ r3,#7
        tbl[4]  = '{1, 32'h36040009, 1, 4'd3, 1, 1, 0, 0, 4'h6, 4'b0110, 7};   // MOVLT r4,#9
        tbl[5]  = '{0, 32'h0,        1, 4'd4, 1, 0, 0, 0, 4'h0, 4'b0110, 0};   // MOVLT not taken
        tbl[6]  = '{1, 32'h00052300, 1, 4'd5, 1, 1, 10, 7, 4'h0, 4'b0110, 0};  // ADD r5,r2,r3
        tbl[7]  = '{1, 32'h06060001, 0, 4'd5, 0, 1, 10, 7, 4'h0, 4'b0110, 0};  // stall
        tbl[8]  = '{1, 32'h06060001, 0, 4'd5, 0, 1, 10, 7, 4'h0, 4'b0110, 0};
        tbl[9]  = '{1, 32'h06060001, 0, 4'd5, 0, 1, 10, 7, 4'h0, 4'b0110, 0};
        tbl[10] = '{1, 32'h06060001, 1, 4'd5, 1, 1, 0, 0, 4'h6, 4'b0110, 17};  // release: wb + capture
        tbl[11] = '{0, 32'h0,        1, 4'd6, 1, 0, 0, 0, 4'h0, 4'b0110, 1};
        tbl[12] = '{1, 32'h00882300, 1, 4'd8, 1, 1, 10, 7, 4'h0, 4'b0110, 0};  // ADDS r8,r2,r3
        tbl[13] = '{1, 32'h00070400, 1, 4'd8, 1, 1, 0, 0, 4'h0, 4'b0010, 17};  // ADD r7 s=0
        tbl[14] = '{1, 32'h00890400, 1, 4'd7, 1, 1, 0, 0, 4'h0, 4'b0010, 0};   // ADDS r9 = 0
        tbl[15] = '{1, 32'h0A0A2300, 1, 4'd9, 1, 1, 10, 7, 4'hA, 4'b0110, 0};  // STR
        tbl[16] = '{1, 32'h090B2300, 1, 4'd10, 1, 1, 10, 7, 4'h9, 4'b0110, 0}; // LDR
        tbl[17] = '{1, 32'h0F0C2300, 1, 4'd11, 1, 1, 10, 7, 4'hF, 4'b0110, 0}; // NOP
        tbl[18] = '{0, 32'h0,        1, 4'd12, 1, 0, 0, 0, 4'h0, 4'b0110, 0};

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst_iv", 0, 32'(issue_valid), 32'h0);
        chk("rst_op", 0, 32'(opcode), 32'hF);
        chk("rst_flags", 0, 32'(inflags), 32'h0);
        chk("rst_rdy", 0, 32'(instr_ready), 32'h1);
        chk("rst_in1", 0, in1, 32'h0);
        for (int a = 0; a < 16; a++) begin
            @(negedge clk);
            dbg_addr = 4'(a);
            #1 chk("rst_reg", a, dbg_data, 32'h0);
        end

        // Directed vectors
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            instr_valid = tbl[i].vld;
            instr       = tbl[i].ins;
            exe_ready   = tbl[i].er;
            dbg_addr    = tbl[i].dba;
            #1 chk("vec_rdy", i, 32'(instr_ready), 32'(tbl[i].rdy));
            @(posedge clk);
            #2;
            chk("vec_iv", i, 32'(issue_valid), 32'(tbl[i].iv));
            if (tbl[i].iv) begin
                chk("vec_in1", i, in1, tbl[i].in1);
                chk("vec_in2", i, in2, tbl[i].in2);
                chk("vec_op", i, 32'(opcode), 32'(tbl[i].op));
            end
            chk("vec_flags", i, 32'(inflags), 32'(tbl[i].flg));
            chk("vec_dbg", i, dbg_data, tbl[i].dbg);
        end

        // Reset while a stalled ADD r13 is in the issue register
        @(negedge clk);
        instr_valid = 1'b1; instr = 32'h000D2300; exe_ready = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0; exe_ready = 1'b0;
        @(negedge clk);
        #1 chk("mid_iv_before", 0, 32'(issue_valid), 32'h1);
        reset = 1'b0;
        #1;
        chk("mid_iv", 0, 32'(issue_valid), 32'h0);
        chk("mid_op", 0, 32'(opcode), 32'hF);
        chk("mid_flags", 0, 32'(inflags), 32'h0);
        @(negedge clk);
        reset = 1'b1; exe_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("mid_iv_after", 0, 32'(issue_valid), 32'h0);
        for (int a = 0; a < 16; a++) begin
            @(negedge clk);
            dbg_addr = 4'(a);
            #1 chk("mid_reg", a, dbg_data, 32'h0);
        end

        // Random phase against the reference model (state is post-reset)
        for (int a = 0; a < 16; a++) m_regs[a] = '0;
        m_flags = '0; m_iv = 0; m_ins = '0; m_in1 = '0; m_in2 = '0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            logic        v, er, ret, ready;
            logic [31:0] ins, res;
            logic [3:0]  fl, dba;
            logic [35:0] ar;
            logic [31:0] nregs [16];
            logic [3:0]  nflags;
            v   = ($urandom_range(0, 3) != 0);
            er  = ($urandom_range(0, 3) != 0);
            dba = 4'($urandom_range(0, 15));
            ins = {4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                   3'($urandom_range(0, 7)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                   4'($urandom_range(0, 3)), 8'($urandom_range(0, 255))};
            @(negedge clk);
            instr_valid = v; instr = ins; exe_ready = er; dbg_addr = dba;
            #1 chk("rnd_rdy", cyc, 32'(instr_ready), 32'(!m_iv || er));

            // Operand reads observe the register file as it stands after the
            // retiring instruction's writeback.
            for (int a = 0; a < 16; a++) nregs[a] = m_regs[a];
            nflags = m_flags;
            ret = m_iv && er;
            if (ret && cond_ok(m_ins[31:28], m_flags)) begin
                ar = alu_fn(m_ins[27:24], m_in1, m_in2, m_ins[15:0]);
                {fl, res} = ar;
                if (m_ins[27:24] < 4'd8) nregs[m_ins[19:16]] = res;
                if (m_ins[23] || m_ins[27:24] == 4'd8) nflags = fl;
            end
            ready = !m_iv || er;
            if (v && ready) begin
                m_ins = ins;
                m_in1 = nregs[ins[15:12]];
                m_in2 = nregs[ins[11:8]];
                m_iv  = 1;
            end else if (ret) begin
                m_iv = 0;
            end
            for (int a = 0; a < 16; a++) m_regs[a] = nregs[a];
            m_flags = nflags;

            @(posedge clk);
            #2;
            chk("rnd_iv", cyc, 32'(issue_valid), 32'(m_iv));
            if (m_iv) begin
                chk("rnd_in1", cyc, in1, m_in1);
                chk("rnd_in2", cyc, in2, m_in2);
                chk("rnd_fields", cyc, {4'h0, cond, opcode, sbit, srcontrol, imvalue}, {4'h0, m_ins[31:20], m_ins[15:0]});
            end
            chk("rnd_flags", cyc, 32'(inflags), 32'(m_flags));
            chk("rnd_dbg", cyc, dbg_data, m_regs[dba]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
